// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider state encoding and the ALU control codes
// from which the decoder derives the divider's start/signed_div strobes.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

    // True when the alucontrol code selects either divide flavour.
    function automatic logic isDivOp(input logic [3:0] aluControl);
        return (aluControl == ALU_DIV) || (aluControl == ALU_DIVU);
    endfunction

    // True when the alucontrol code selects the two's complement divide.
    function automatic logic isSignedDiv(input logic [3:0] aluControl);
        return aluControl == ALU_DIV;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one, trial
// subtract the divisor magnitude and keep the difference when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // Trial subtraction on the widened partial remainder.
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        fits    = shifted >= {1'b0, divisor};
        // When the divisor fits, the difference is below the divisor and
        // therefore representable in WIDTH bits.
        remOut  = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
        quoOut  = {quoIn[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Produces {remainder, quotient} for hi/lo and a combinational stall request.
// Optional: DIV_BYZERO_FAST_EN makes a zero divisor skip the iteration.
module div_iter
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               div_running,
    output logic               done,
    output logic [2*WIDTH-1:0] hilo,
    output logic               dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    divState_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dmag, aRaw;
    logic             qsign, rsign, dzero;
    logic [WIDTH-1:0] remNext, quoNext;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH-1:0] qFinal, rFinal;

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn  (rem),
        .quoIn  (quo),
        .divisor(dmag),
        .remOut (remNext),
        .quoOut (quoNext)
    );

    // Operand magnitudes for the signed path.
    always_comb begin
        aMag = (signed_div & a[WIDTH-1]) ? -a : a;
        bMag = (signed_div & b[WIDTH-1]) ? -b : b;
    end

    // Sign correction of the final step's result; a zero divisor forces the
    // all-ones quotient and the raw dividend regardless of signedness.
    always_comb begin
        qFinal = qsign ? -quoNext : quoNext;
        rFinal = rsign ? -remNext : remNext;
        if (dzero) begin
            qFinal = '1;
            rFinal = aRaw;
        end
    end

    // Stall request: asserted in the start cycle itself, then throughout BUSY.
    always_comb begin
        div_running = (state == BUSY) | ((state == IDLE) & start & ~cancel);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dmag  <= '0;
            aRaw  <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            dzero <= 1'b0;
            hilo  <= '0;
            dbz   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rem   <= '0;
                            quo   <= aMag;
                            dmag  <= bMag;
                            aRaw  <= a;
                            qsign <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rsign <= signed_div & a[WIDTH-1];
                            dzero <= (b == '0);
                            cnt   <= '0;
`ifdef DIV_BYZERO_FAST_EN
                            if (b == '0) begin
                                state <= DONE;
                                hilo  <= {a, {WIDTH{1'b1}}};
                                dbz   <= 1'b1;
                                done  <= 1'b1;
                            end else begin
                                state <= BUSY;
                            end
`else
                            state <= BUSY;
`endif
                        end
                    end
                    BUSY: begin
                        rem <= remNext;
                        quo <= quoNext;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= DONE;
                            hilo  <= {rFinal, qFinal};
                            dbz   <= dzero;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: a 32-bit and an 8-bit instance.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst, start, signedDiv, cancel;
    logic [31:0] a, b;
    logic        running, done, dbz;
    logic [63:0] hilo;

    logic        start8, signed8, cancel8;
    logic [7:0]  a8, b8;
    logic        running8, done8, dbz8;
    logic [15:0] hilo8;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .signed_div(signedDiv),
        .a(a), .b(b), .cancel(cancel), .div_running(running),
        .done(done), .hilo(hilo), .dbz(dbz)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_div(signed8),
        .a(a8), .b(b8), .cancel(cancel8), .div_running(running8),
        .done(done8), .hilo(hilo8), .dbz(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one 32-bit division, optionally pulsing a stray start at cycle injectAt.
    task automatic runDiv(input string tag, input logic sd, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] expHilo,
                          input logic expDbz, input int expLat, input int injectAt);
        int n, runHigh, extra;
        logic seenDone, runAtDone;
        @(negedge clk);
        start = 1'b1; signedDiv = sd; a = av; b = bv;
        #1 check({tag, ".runStart"}, 64'(running), 64'd1);
        @(posedge clk);
        #1 start = 1'b0; a = '0; b = '0;
        n = 0; runHigh = 0; seenDone = 1'b0; runAtDone = 1'b1;
        while (n < 100 && !seenDone) begin
            @(negedge clk);
            n++;
            if (start) start = 1'b0;
            if (done) begin
                seenDone = 1'b1;
                runAtDone = running;
            end else begin
                if (running) runHigh++;
                if (injectAt == n) begin
                    start = 1'b1; signedDiv = 1'b0; a = 32'd1000; b = 32'd1;
                end
            end
        end
        check({tag, ".latency"}, 64'(n), 64'(expLat));
        check({tag, ".hilo"}, hilo, expHilo);
        check({tag, ".dbz"}, 64'(dbz), 64'(expDbz));
        check({tag, ".runAtDone"}, 64'(runAtDone), 64'd0);
        check({tag, ".runCycles"}, 64'(runHigh), 64'(expLat - 1));
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, ".extraDone"}, 64'(extra), 64'd0);
        check({tag, ".hiloHeld"}, hilo, expHilo);
    endtask

    task automatic runDiv8(input string tag, input logic sd, input logic [7:0] av,
                           input logic [7:0] bv, input logic [15:0] expHilo,
                           input logic expDbz, input int expLat);
        int n;
        @(negedge clk);
        start8 = 1'b1; signed8 = sd; a8 = av; b8 = bv;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 0;
        while (n < 40 && !done8) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(expLat));
        check({tag, ".hilo"}, 64'(hilo8), 64'(expHilo));
        check({tag, ".dbz"}, 64'(dbz8), 64'(expDbz));
    endtask

    initial begin
        int n, cnt;
        logic seen;
        int dbzLat32, dbzLat8;
`ifdef DIV_BYZERO_FAST_EN
        dbzLat32 = 1;
        dbzLat8  = 1;
`else
        dbzLat32 = 33;
        dbzLat8  = 9;
`endif
        rst = 1'b1; start = 1'b0; signedDiv = 1'b0; cancel = 1'b0; a = '0; b = '0;
        start8 = 1'b0; signed8 = 1'b0; cancel8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.hilo", hilo, 64'd0);
        check("rst.dbz", 64'(dbz), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.running", 64'(running), 64'd0);
        check("rst.hilo8", 64'(hilo8), 64'd0);
        rst = 1'b0;

        runDiv("u100by7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 0);
        runDiv("sNeg7by2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33, 0);
        runDiv("s7byNeg2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0, 33, 0);
        runDiv("sOverflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 33, 0);
        runDiv("uBig", 1'b0, 32'hFFFFFFFF, 32'd10, {32'd5, 32'h19999999}, 1'b0, 33, 0);
        runDiv("uMinBy1s", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 1'b0, 33, 0);
        runDiv("u5by0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, dbzLat32, 0);
        runDiv("sNeg5by0", 1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, dbzLat32, 0);
        runDiv("u9by3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33, 0);
        runDiv("inject", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 5);

        // Flush at cycle t+10, then restart right after.
        @(negedge clk);
        start = 1'b1; signedDiv = 1'b0; a = 32'd77; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel.running", 64'(running), 64'd0);
        check("cancel.done", 64'(done | seen), 64'd0);
        check("cancel.hilo", hilo, {32'd2, 32'd14});
        runDiv("restart", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33, 0);

        // Start and cancel together in IDLE: nothing starts.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd7;
        #1 check("startCancel.running", 64'(running), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        cnt = 0;
        repeat (36) begin
            @(negedge clk);
            if (done || running) cnt++;
        end
        check("startCancel.activity", 64'(cnt), 64'd0);
        check("startCancel.hilo", hilo, {32'd0, 32'd3});

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; signedDiv = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midRst.running", 64'(running), 64'd0);
        check("midRst.hilo", hilo, 64'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (36) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("midRst.noDone", 64'(cnt), 64'd0);

        runDiv8("w8u200by3", 1'b0, 8'd200, 8'd3, {8'd2, 8'd66}, 1'b0, 9);
        runDiv8("w8sOverflow", 1'b1, 8'h80, 8'hFF, {8'd0, 8'h80}, 1'b0, 9);
        runDiv8("w8u7by0", 1'b0, 8'd7, 8'd0, {8'd7, 8'hFF}, 1'b1, dbzLat8);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
